// File: rtl/sc_fifo_burst_reader.sv
// Read-side master for a single-clock show-ahead FIFO: pops words into a
// 2-entry output buffer and presents them as a valid/ready stream, optionally framed in bursts.
module sc_fifo_burst_reader #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    input  logic [ADDR_W:0]   fifo_usedw_i,
    input  logic              burst_mode_i,
    input  logic              flush_i,
    output logic              src_valid_o,
    output logic [DATA_W-1:0] src_data_o,
    output logic              src_last_o,
    input  logic              src_ready_i,
    output logic              busy_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] ONE_C       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_BURST  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    state_e            state_r;
    state_e            state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic [CNT_W-1:0]  len_r;
    logic [CNT_W-1:0]  len_nx_s;
    logic [1:0]        occ_r;
    logic [1:0]        occ_nx_s;
    logic [DATA_W-1:0] data0_r;
    logic [DATA_W-1:0] data1_r;
    logic              last0_r;
    logic              last1_r;
    logic              valid_r;
    logic              busy_r;
    logic              fetch_allowed_s;
    logic              rd_en_s;
    logic              pop_s;
    logic              push_last_s;

    // Fetch decision: depends only on registered state and FIFO flags, never on src_ready_i.
    always_comb begin
        fetch_allowed_s = 1'b0;
        case (state_r)
            ST_STREAM: fetch_allowed_s = 1'b1;
            ST_BURST:  fetch_allowed_s = (cnt_r < len_r);
            default:   fetch_allowed_s = 1'b0;
        endcase
        rd_en_s     = fetch_allowed_s && !fifo_empty_i && (occ_r != 2'd2);
        pop_s       = valid_r && src_ready_i;
        push_last_s = (state_r == ST_BURST) && ((cnt_r + ONE_C) == len_r);
        occ_nx_s    = occ_r + {1'b0, rd_en_s} - {1'b0, pop_s};
        fifo_rd_en_o = rd_en_s && rst_n_i;
    end

    // Next-state, burst counter and latched burst length.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        len_nx_s   = len_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = ZERO_C;
                if (!burst_mode_i) begin
                    if (!fifo_empty_i) begin
                        state_nx_s = ST_STREAM;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else if (fifo_usedw_i >= BURST_LEN_C) begin
                    state_nx_s = ST_BURST;
                    len_nx_s   = BURST_LEN_C;
                end else if (flush_i && !fifo_empty_i) begin
                    // Threshold not met here, so usedw is already the min of usedw and BURST_LEN.
                    state_nx_s = ST_BURST;
                    len_nx_s   = fifo_usedw_i;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (fifo_empty_i) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STREAM;
                end
            end
            ST_BURST: begin
                if (rd_en_s) begin
                    cnt_nx_s = cnt_r + ONE_C;
                    if (push_last_s) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_BURST;
                    end
                end else begin
                    state_nx_s = ST_BURST;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (occ_r == 2'd1)) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = ZERO_C;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = ZERO_C;
            end
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= ZERO_C;
            len_r   <= ZERO_C;
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            len_r   <= len_nx_s;
            occ_r   <= occ_nx_s;
            valid_r <= (occ_nx_s != 2'd0);
            busy_r  <= (state_nx_s != ST_IDLE) || (occ_nx_s != 2'd0);
        end
    end

    // Two-entry output buffer; entry 0 is the head and only moves on pop or on a push into an empty slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data0_r <= {DATA_W{1'b0}};
            data1_r <= {DATA_W{1'b0}};
            last0_r <= 1'b0;
            last1_r <= 1'b0;
        end else begin
            if (pop_s) begin
                data0_r <= data1_r;
                last0_r <= last1_r;
            end
            if (rd_en_s) begin
                if ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s)) begin
                    data0_r <= fifo_data_i;
                    last0_r <= push_last_s;
                end else begin
                    data1_r <= fifo_data_i;
                    last1_r <= push_last_s;
                end
            end
        end
    end

    assign src_valid_o = valid_r;
    assign src_data_o  = data0_r;
    assign src_last_o  = last0_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_sc_fifo_burst_reader.sv
// Self-checking bench: behavioural show-ahead FIFO, occupancy/order scoreboard,
// directed scenarios followed by randomized streaming and burst traffic.
module tb_sc_fifo_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        fifo_rd_en;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_usedw;
    logic        mode;
    logic        flush;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_last;
    logic        src_ready;
    logic        busy;

    sc_fifo_burst_reader #(.DATA_W(16), .ADDR_W(4), .BURST_LEN(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .fifo_rd_en_o(fifo_rd_en),
        .fifo_data_i (fifo_data),
        .fifo_empty_i(fifo_empty),
        .fifo_usedw_i(fifo_usedw),
        .burst_mode_i(mode),
        .flush_i     (flush),
        .src_valid_o (src_valid),
        .src_data_o  (src_data),
        .src_last_o  (src_last),
        .src_ready_i (src_ready),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: wr_k staged words are written per clock, one word popped per rd_en.
    logic [15:0] fmem [0:15];
    logic [15:0] stage [0:15];
    logic [3:0]  fwp;
    logic [3:0]  frp;
    logic [4:0]  fcnt;
    int          wr_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwp  <= 4'd0;
            frp  <= 4'd0;
            fcnt <= 5'd0;
        end else begin
            for (int i = 0; i < wr_k; i++) fmem[fwp + 4'(i)] <= stage[i];
            fwp  <= fwp + 4'(wr_k);
            frp  <= frp + 4'(fifo_rd_en);
            fcnt <= fcnt + 5'(wr_k) - 5'(fifo_rd_en);
        end
    end

    assign fifo_data  = fmem[frp];
    assign fifo_empty = (fcnt == 5'd0);
    assign fifo_usedw = fcnt;

    int          n_tests;
    int          n_fail;
    int          occ_m;
    int          rd_total;
    int          cyc_no;
    int          first_rd;
    int          last_rd;
    int          first_acc;
    bit          stall_p;
    logic [15:0] stall_d;
    logic        stall_l;
    logic [15:0] exp_d [$];
    bit          exp_l [$];

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_tests++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic obs();
        bit          acc;
        logic [15:0] ed;
        bit          el;
        chk("valid_vs_occ", 32'(src_valid), 32'(occ_m != 0));
        if (occ_m >= 2) chk("rden_while_full", 32'(fifo_rd_en), 32'd0);
        if (fifo_rd_en) chk("rden_while_empty", 32'(fifo_empty), 32'd0);
        if (stall_p) begin
            chk("stall_data", 32'(src_data), 32'(stall_d));
            chk("stall_last", 32'(src_last), 32'(stall_l));
        end
        acc = src_valid && src_ready;
        if (acc) begin
            chk("exp_avail", 32'(exp_d.size() != 0 && exp_l.size() != 0), 32'd1);
            if (exp_d.size() != 0 && exp_l.size() != 0) begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                chk("word_data", 32'(src_data), 32'(ed));
                chk("word_last", 32'(src_last), 32'(el));
            end
            if (first_acc < 0) first_acc = cyc_no;
        end
        if (fifo_rd_en) begin
            rd_total++;
            if (first_rd < 0) first_rd = cyc_no;
            last_rd = cyc_no;
        end
        occ_m   = occ_m + int'(fifo_rd_en) - int'(acc);
        stall_p = src_valid && !src_ready;
        stall_d = src_data;
        stall_l = src_last;
        cyc_no++;
    endtask

    task automatic tick();
        #1;
        obs();
        @(negedge clk);
        wr_k  = 0;
        flush = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_bulk(input int n);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            stage[i] = d;
            exp_d.push_back(d);
        end
        wr_k = n;
    endtask

    task automatic push_l(input int n, input bit last_end);
        for (int i = 0; i < n; i++) exp_l.push_back(last_end && (i == n - 1));
    endtask

    task automatic wait_drain(input int bound);
        int c;
        c = 0;
        while ((fcnt != 5'd0 || busy || src_valid) && c < bound) begin
            tick();
            c++;
        end
        chk("drain_in_time", 32'(c < bound), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n_words;
        int k;
        int c;
        int full;

        n_tests = 0; n_fail = 0; occ_m = 0; rd_total = 0; cyc_no = 0;
        first_rd = -1; last_rd = -1; first_acc = -1; stall_p = 1'b0;
        stall_d = 16'd0; stall_l = 1'b0;
        rst_n = 1'b0; src_ready = 1'b0; mode = 1'b0; flush = 1'b0; wr_k = 0;

        // Reset values
        #7;
        chk("rst_valid", 32'(src_valid), 32'd0);
        chk("rst_data",  32'(src_data),  32'd0);
        chk("rst_last",  32'(src_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_rden",  32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // Streaming: 5 words, continuous ready
        mode = 1'b0; src_ready = 1'b1;
        r0 = rd_total; first_rd = -1; first_acc = -1;
        wr_bulk(5); push_l(5, 1'b0);
        run(14);
        chk("stream_reads", 32'(rd_total - r0), 32'd5);
        chk("stream_consecutive", 32'(last_rd - first_rd), 32'd4);
        chk("stream_latency", 32'(first_acc - first_rd), 32'd1);
        chk("stream_all_out", 32'(exp_d.size()), 32'd0);
        chk("stream_busy_low", 32'(busy), 32'd0);

        // Backpressure: 8 words, ready 1,0,0 repeating
        r0 = rd_total;
        wr_bulk(8); push_l(8, 1'b0);
        for (int i = 0; i < 40; i++) begin
            src_ready = (i % 3 == 0);
            tick();
        end
        chk("bp_reads", 32'(rd_total - r0), 32'd8);
        chk("bp_all_out", 32'(exp_d.size()), 32'd0);
        src_ready = 1'b1;
        run(3);

        // Burst threshold: 3 words do not start a burst, 4th does, 5th waits
        mode = 1'b1; r0 = rd_total;
        push_l(4, 1'b1); push_l(4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wr_bulk(1);
            tick();
        end
        run(5);
        chk("thr_no_read", 32'(rd_total - r0), 32'd0);
        wr_bulk(1); tick();
        wr_bulk(1); tick();
        run(12);
        chk("thr_reads", 32'(rd_total - r0), 32'd4);
        chk("thr_word5_left", 32'(fcnt), 32'd1);
        chk("thr_idle", 32'(busy), 32'd0);
        wr_bulk(3); tick();
        run(12);
        chk("thr_second_burst", 32'(rd_total - r0), 32'd8);
        chk("thr_fifo_empty", 32'(fcnt), 32'd0);

        // Flush: short burst of 3, then flush with usedw above BURST_LEN
        r0 = rd_total;
        wr_bulk(3); push_l(3, 1'b1);
        run(6);
        chk("flush_wait", 32'(rd_total - r0), 32'd0);
        flush = 1'b1; tick();
        run(10);
        chk("flush_reads", 32'(rd_total - r0), 32'd3);
        chk("flush_idle", 32'(busy), 32'd0);
        r0 = rd_total;
        wr_bulk(6); push_l(4, 1'b1); push_l(2, 1'b1);
        tick();
        flush = 1'b1; tick();
        run(12);
        chk("flush_full_burst", 32'(rd_total - r0), 32'd4);
        chk("flush_residual", 32'(fcnt), 32'd2);
        flush = 1'b1; tick();
        run(8);
        chk("flush_residual_out", 32'(rd_total - r0), 32'd6);
        chk("flush_fifo_empty", 32'(fcnt), 32'd0);

        // Burst stalled by the sink while the FIFO is refilled, then a flush burst with a writer active
        r0 = rd_total; src_ready = 1'b0;
        wr_bulk(4); push_l(4, 1'b1);
        run(8);
        chk("stall_reads", 32'(rd_total - r0), 32'd2);
        wr_bulk(2); push_l(2, 1'b1);
        tick();
        chk("stall_usedw", 32'(fcnt), 32'd4);
        src_ready = 1'b1;
        run(10);
        chk("stall_burst_done", 32'(rd_total - r0), 32'd4);
        chk("stall_leftover", 32'(fcnt), 32'd2);
        chk("stall_idle", 32'(busy), 32'd0);
        push_l(4, 1'b1);
        flush = 1'b1; tick();
        wr_bulk(1); tick();
        wr_bulk(1); tick();
        run(8);
        chk("len2_reads", 32'(rd_total - r0), 32'd6);
        chk("len2_leftover", 32'(fcnt), 32'd2);
        wr_bulk(2); tick();
        run(10);
        chk("len2_next_burst", 32'(rd_total - r0), 32'd10);
        chk("len2_all_out", 32'(exp_d.size()), 32'd0);

        // Reset in the middle of a burst
        r0 = rd_total; src_ready = 1'b0;
        wr_bulk(4); push_l(4, 1'b1);
        run(6);
        chk("prerst_reads", 32'(rd_total - r0), 32'd2);
        chk("prerst_valid", 32'(src_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(src_valid), 32'd0);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_rden",  32'(fifo_rd_en), 32'd0);
        exp_d.delete(); exp_l.delete();
        occ_m = 0; stall_p = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(3);
        chk("postrst_busy", 32'(busy), 32'd0);
        mode = 1'b0; src_ready = 1'b1; r0 = rd_total;
        wr_bulk(2); push_l(2, 1'b0);
        run(8);
        chk("postrst_stream", 32'(rd_total - r0), 32'd2);
        chk("postrst_all_out", 32'(exp_d.size()), 32'd0);

        // Random streaming traffic
        mode = 1'b0;
        for (int i = 0; i < 150; i++) begin
            src_ready = ($urandom_range(0, 1) == 1);
            if (fcnt < 5'd14 && $urandom_range(0, 1) == 1) begin
                wr_bulk(1);
                push_l(1, 1'b0);
            end
            tick();
        end
        src_ready = 1'b1;
        wait_drain(60);
        chk("rstream_all_out", 32'(exp_d.size()), 32'd0);

        // Random burst traffic: full bursts of 4, residual flushed at the end
        mode = 1'b1;
        n_words = 10 + int'($urandom_range(0, 9));
        full = n_words - (n_words % 4);
        for (int i = 0; i < n_words; i++)
            exp_l.push_back((i < full) ? (i % 4 == 3) : (i == n_words - 1));
        k = 0; c = 0;
        while (k < n_words && c < 400) begin
            src_ready = ($urandom_range(0, 1) == 1);
            if (fcnt < 5'd14 && $urandom_range(0, 1) == 1) begin
                wr_bulk(1);
                k++;
            end
            tick();
            c++;
        end
        chk("rburst_writes", 32'(k), 32'(n_words));
        src_ready = 1'b1;
        run(20);
        chk("rburst_residual", 32'(fcnt), 32'(n_words % 4));
        flush = 1'b1; tick();
        wait_drain(60);
        chk("rburst_all_out", 32'(exp_d.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
